// File: rtl/vpifo_pkg.sv
// vpifo_pkg: types and constants shared by the PIFO port adapter and its
// command queue.
//   PTW           - priority/data width
//   TREE_NUM      - number of virtual trees behind one PIFO port
//   TREE_NUM_BITS - width of a tree id
//   op_e          - command opcode (push/pop)
//   cmd_t         - queued command {op, tree_id, data}
//   rsp_t         - response payload {err, tree_id, data}
package vpifo_pkg;

   localparam int PTW           = 16;
   localparam int TREE_NUM      = 4;
   localparam int TREE_NUM_BITS = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1;

   typedef enum logic {
      OP_PUSH = 1'b0,
      OP_POP  = 1'b1
   } op_e;

   typedef struct packed {
      op_e                      op;
      logic [TREE_NUM_BITS-1:0] tree_id;
      logic [PTW-1:0]           data;
   } cmd_t;

   typedef struct packed {
      logic                     err;
      logic [TREE_NUM_BITS-1:0] tree_id;
      logic [PTW-1:0]           data;
   } rsp_t;

endpackage

// File: rtl/vpifo_cmd_fifo.sv
// vpifo_cmd_fifo: synchronous FIFO of commands, depth QDEPTH (power of 2).
//   clk, arst_n - clock, asynchronous active-low reset
//   wr_en       - write wr_cmd (ignored when full)
//   rd_en       - pop the head (ignored when empty)
//   rd_cmd      - current head, meaningful only when count != 0
//   count       - occupancy, 0..QDEPTH
module vpifo_cmd_fifo
   import vpifo_pkg::*;
#(
   parameter int QDEPTH = 8
) (
   input  logic                      clk,
   input  logic                      arst_n,
   input  logic                      wr_en,
   input  cmd_t                      wr_cmd,
   input  logic                      rd_en,
   output cmd_t                      rd_cmd,
   output logic [$clog2(QDEPTH):0]   count
);

   localparam int AW = $clog2(QDEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(QDEPTH);

   cmd_t          mem [QDEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_wr;
   logic          do_rd;

   assign do_wr  = wr_en && (count != FULL_CNT);
   assign do_rd  = rd_en && (count != '0);
   assign rd_cmd = mem[rd_ptr];

   // NOTE: storage has no reset; the pointers and count define what is valid,
   // so clearing the array would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_cmd;
   end

   // Pointers wrap naturally because QDEPTH is a power of 2.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/vpifo_port_adapter.sv
// vpifo_port_adapter: per-port front end of the virtualised SRAM PIFO.
// Queues tagged push/pop commands, issues at most one per cycle into a PIFO
// level port, filters pops of empty trees and pushes to full trees, and
// returns pop results (and rejections) in issue order at fixed latency.
//   i_clk, i_arst_n      - clock, asynchronous active-low reset
//   i_req_*/o_req_ready  - client command channel (valid/ready)
//   o_push/o_pop/...     - registered PIFO strobes, tree id and push data
//   i_task_fifo_full     - PIFO backpressure, stalls dequeue
//   i_pop_data           - PIFO pop result, POP_LAT cycles after o_pop
//   o_rsp_*              - single-cycle response, in dequeue order
//   o_q_count            - command queue occupancy
module vpifo_port_adapter
   import vpifo_pkg::*;
#(
   parameter int TREE_CAP = 340,
   parameter int QDEPTH   = 8,
   parameter int POP_LAT  = 2
) (
   input  logic                      i_clk,
   input  logic                      i_arst_n,
   input  logic                      i_req_valid,
   output logic                      o_req_ready,
   input  logic                      i_req_op,
   input  logic [TREE_NUM_BITS-1:0]  i_req_tree_id,
   input  logic [PTW-1:0]            i_req_data,
   output logic                      o_push,
   output logic                      o_pop,
   output logic [TREE_NUM_BITS-1:0]  o_tree_id,
   output logic [PTW-1:0]            o_push_data,
   input  logic                      i_task_fifo_full,
   input  logic [PTW-1:0]            i_pop_data,
   output logic                      o_rsp_valid,
   output logic [TREE_NUM_BITS-1:0]  o_rsp_tree_id,
   output logic                      o_rsp_err,
   output logic [PTW-1:0]            o_rsp_data,
   output logic [$clog2(QDEPTH):0]   o_q_count
);

   localparam int QCW   = $clog2(QDEPTH) + 1;
   localparam int CNT_W = $clog2(TREE_CAP + 1);
   localparam logic [QCW-1:0]   Q_FULL = QCW'(QDEPTH);
   localparam logic [CNT_W-1:0] CAP    = CNT_W'(TREE_CAP);

   cmd_t             req_cmd;
   cmd_t             head;
   logic             enq;
   logic             deq;
   logic [CNT_W-1:0] tree_cnt [TREE_NUM];
   logic [CNT_W-1:0] head_cnt;
   logic             issue_push;
   logic             issue_pop;
   logic             rsp_in_valid;
   rsp_t             rsp_in;
   logic             dl_valid [POP_LAT+1];
   rsp_t             dl_rsp   [POP_LAT+1];

   assign req_cmd     = '{op: op_e'(i_req_op), tree_id: i_req_tree_id, data: i_req_data};
   assign o_req_ready = (o_q_count < Q_FULL);
   assign enq         = i_req_valid && o_req_ready;
   assign deq         = (o_q_count != '0) && !i_task_fifo_full;

   vpifo_cmd_fifo #(.QDEPTH(QDEPTH)) u_cmd_fifo (
      .clk    (i_clk),
      .arst_n (i_arst_n),
      .wr_en  (enq),
      .wr_cmd (req_cmd),
      .rd_en  (deq),
      .rd_cmd (head),
      .count  (o_q_count)
   );

   // Dequeue decision: a command either becomes a PIFO strobe or a rejection
   // response. Accepted pops also enter the delay line to carry their tag.
   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      head_cnt     = tree_cnt[head.tree_id];
      issue_push   = 1'b0;
      issue_pop    = 1'b0;
      rsp_in_valid = 1'b0;
      rsp_in       = '0;
      if (deq) begin
         rsp_in.tree_id = head.tree_id;
         if (head.op == OP_PUSH) begin
            if (head_cnt < CAP) begin
               issue_push = 1'b1;
            end else begin
               rsp_in_valid = 1'b1;
               rsp_in.err   = 1'b1;
               rsp_in.data  = head.data;
            end
         end else begin
            rsp_in_valid = 1'b1;
            if (head_cnt != '0) issue_pop = 1'b1;
            else rsp_in.err = 1'b1;
         end
         if (!rsp_in_valid) rsp_in = '0;
      end
   end

   // NOTE: all state below uses non-blocking assignments so every register
   // samples the pre-edge values, regardless of statement order.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         o_push      <= 1'b0;
         o_pop       <= 1'b0;
         o_tree_id   <= '0;
         o_push_data <= '0;
         for (int t = 0; t < TREE_NUM; t++) tree_cnt[t] <= '0;
      end else begin
         o_push      <= issue_push;
         o_pop       <= issue_pop;
         o_tree_id   <= (issue_push || issue_pop) ? head.tree_id : '0;
         o_push_data <= issue_push ? head.data : '0;
         if (issue_push)     tree_cnt[head.tree_id] <= head_cnt + CNT_W'(1);
         else if (issue_pop) tree_cnt[head.tree_id] <= head_cnt - CNT_W'(1);
      end
   end

   // Response delay line: stage k holds the entry k cycles after its strobe
   // cycle; the last stage lines up with i_pop_data of an accepted pop.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         for (int k = 0; k <= POP_LAT; k++) begin
            dl_valid[k] <= 1'b0;
            dl_rsp[k]   <= '0;
         end
         o_rsp_valid   <= 1'b0;
         o_rsp_err     <= 1'b0;
         o_rsp_tree_id <= '0;
         o_rsp_data    <= '0;
      end else begin
         dl_valid[0] <= rsp_in_valid;
         dl_rsp[0]   <= rsp_in;
         for (int k = 1; k <= POP_LAT; k++) begin
            dl_valid[k] <= dl_valid[k-1];
            dl_rsp[k]   <= dl_rsp[k-1];
         end
         o_rsp_valid   <= dl_valid[POP_LAT];
         o_rsp_err     <= dl_rsp[POP_LAT].err;
         o_rsp_tree_id <= dl_rsp[POP_LAT].tree_id;
         o_rsp_data    <= (dl_valid[POP_LAT] && !dl_rsp[POP_LAT].err) ?
                          i_pop_data : dl_rsp[POP_LAT].data;
      end
   end

endmodule

// File: tb/tb_vpifo_port_adapter.sv
// tb_vpifo_port_adapter: directed self-checking bench for vpifo_port_adapter.
// Inputs are driven and outputs sampled on the falling clock edge; a small
// PIFO model returns scripted pop data POP_LAT cycles after each o_pop.
module tb_vpifo_port_adapter;

   logic        i_clk = 1'b0;
   logic        i_arst_n = 1'b0;
   logic        i_req_valid = 1'b0;
   logic        o_req_ready;
   logic        i_req_op = 1'b0;
   logic [1:0]  i_req_tree_id = '0;
   logic [15:0] i_req_data = '0;
   logic        o_push;
   logic        o_pop;
   logic [1:0]  o_tree_id;
   logic [15:0] o_push_data;
   logic        i_task_fifo_full = 1'b0;
   logic [15:0] i_pop_data = 16'hDEAD;
   logic        o_rsp_valid;
   logic [1:0]  o_rsp_tree_id;
   logic        o_rsp_err;
   logic [15:0] o_rsp_data;
   logic [3:0]  o_q_count;

   vpifo_port_adapter dut (
      .i_clk(i_clk), .i_arst_n(i_arst_n),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_req_op(i_req_op), .i_req_tree_id(i_req_tree_id), .i_req_data(i_req_data),
      .o_push(o_push), .o_pop(o_pop), .o_tree_id(o_tree_id), .o_push_data(o_push_data),
      .i_task_fifo_full(i_task_fifo_full), .i_pop_data(i_pop_data),
      .o_rsp_valid(o_rsp_valid), .o_rsp_tree_id(o_rsp_tree_id), .o_rsp_err(o_rsp_err),
      .o_rsp_data(o_rsp_data), .o_q_count(o_q_count)
   );

   always #5 i_clk = ~i_clk;

   typedef struct { int cyc; bit pop; logic [1:0] tree; logic [15:0] data; } strb_t;
   typedef struct { int cyc; logic err; logic [1:0] tree; logic [15:0] data; } rsp_rec_t;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          viol = 0;
   int          last_acc = 0;
   strb_t       sq[$];
   rsp_rec_t    rq[$];
   logic [15:0] script[$];
   logic [15:0] pend[3] = '{16'hDEAD, 16'hDEAD, 16'hDEAD};

   always @(posedge i_clk) cyc <= cyc + 1;

   // Monitor: record strobes and responses, flag illegal strobe encodings.
   always @(negedge i_clk) begin
      if (o_push || o_pop) sq.push_back('{cyc, o_pop, o_tree_id, o_push_data});
      if (o_rsp_valid) rq.push_back('{cyc, o_rsp_err, o_rsp_tree_id, o_rsp_data});
      if ((o_push && o_pop) || (o_pop && o_push_data != 0) ||
          (!o_push && !o_pop && (o_tree_id != 0 || o_push_data != 0)))
         viol++;
   end

   // PIFO model: data for a pop seen in cycle C is presented in cycle C+2.
   always @(negedge i_clk) begin
      pend[2] = pend[1];
      pend[1] = pend[0];
      pend[0] = 16'hDEAD;
      if (o_pop) begin
         if (script.size() > 0) pend[0] = script.pop_front();
         else pend[0] = 16'hC0DE;
      end
      i_pop_data = pend[2];
   end

   task automatic idle(input int n);
      repeat (n) @(negedge i_clk);
   endtask

   task automatic do_reset();
      i_req_valid = 1'b0;
      i_task_fifo_full = 1'b0;
      i_arst_n = 1'b0;
      idle(2);
      script.delete();
      sq.delete();
      rq.delete();
      i_arst_n = 1'b1;
      idle(1);
   endtask

   // Present one command for one accepted cycle; called on a falling edge.
   task automatic send(input logic op, input logic [1:0] tree, input logic [15:0] data);
      int n = 0;
      while (!o_req_ready && n < 50) begin
         @(negedge i_clk);
         n++;
      end
      if (!o_req_ready) begin
         checks++; failures++;
         $display("FAIL send_timeout: o_req_ready still %b, required 1", o_req_ready);
         return;
      end
      i_req_valid = 1'b1;
      i_req_op = op;
      i_req_tree_id = tree;
      i_req_data = data;
      last_acc = cyc + 1;
      @(negedge i_clk);
      i_req_valid = 1'b0;
   endtask

   task automatic test_reset();
      i_arst_n = 1'b0;
      idle(2);
      checks++;
      if ({o_req_ready, o_q_count} !== {1'b1, 4'd0}) begin
         failures++;
         $display("FAIL reset_ready_count: got ready=%b count=%0d, required 1/0", o_req_ready, o_q_count);
      end
      checks++;
      if ({o_push, o_pop, o_tree_id, o_push_data} !== '0) begin
         failures++;
         $display("FAIL reset_pifo_outs: got push=%b pop=%b tree=%0d data=%h, required all 0",
                  o_push, o_pop, o_tree_id, o_push_data);
      end
      checks++;
      if ({o_rsp_valid, o_rsp_err, o_rsp_tree_id, o_rsp_data} !== '0) begin
         failures++;
         $display("FAIL reset_rsp_outs: got v=%b e=%b t=%0d d=%h, required all 0",
                  o_rsp_valid, o_rsp_err, o_rsp_tree_id, o_rsp_data);
      end
      i_arst_n = 1'b1;
      idle(1);
   endtask

   task automatic test_push_pop();
      int a;
      logic        ep[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic [15:0] ed[4] = '{16'h0010, 16'h0005, 16'h0000, 16'h0000};
      do_reset();
      script.push_back(16'h0005);
      script.push_back(16'h0010);
      send(1'b0, 2'd2, 16'h0010);
      a = last_acc;
      send(1'b0, 2'd2, 16'h0005);
      send(1'b1, 2'd2, 16'h0000);
      send(1'b1, 2'd2, 16'h0000);
      idle(10);
      checks++;
      if (sq.size() !== 4) begin
         failures++;
         $display("FAIL pp_strobe_count: got %0d, required 4", sq.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (sq[i].pop !== ep[i] || sq[i].tree !== 2'd2 || sq[i].data !== ed[i] || sq[i].cyc !== a + 1 + i) begin
               failures++;
               $display("FAIL pp_strobe%0d: got pop=%b tree=%0d data=%h cyc=%0d, required pop=%b tree=2 data=%h cyc=%0d",
                        i, sq[i].pop, sq[i].tree, sq[i].data, sq[i].cyc, ep[i], ed[i], a + 1 + i);
            end
         end
      end
      checks++;
      if (rq.size() !== 2) begin
         failures++;
         $display("FAIL pp_rsp_count: got %0d, required 2", rq.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (rq[i].err !== 1'b0 || rq[i].tree !== 2'd2 || rq[i].data !== (i == 0 ? 16'h0005 : 16'h0010) ||
                rq[i].cyc !== a + 6 + i) begin
               failures++;
               $display("FAIL pp_rsp%0d: got err=%b tree=%0d data=%h cyc=%0d, required err=0 tree=2 data=%h cyc=%0d",
                        i, rq[i].err, rq[i].tree, rq[i].data, rq[i].cyc, (i == 0 ? 16'h0005 : 16'h0010), a + 6 + i);
            end
         end
      end
   endtask

   task automatic test_pop_empty();
      int a;
      do_reset();
      send(1'b1, 2'd1, 16'h1234);
      a = last_acc;
      idle(8);
      checks++;
      if (sq.size() !== 0) begin
         failures++;
         $display("FAIL pe_no_strobe: got %0d strobes, required 0", sq.size());
      end
      checks++;
      if (rq.size() !== 1 || rq[0].err !== 1'b1 || rq[0].tree !== 2'd1 || rq[0].data !== 16'h0 || rq[0].cyc !== a + 4) begin
         failures++;
         $display("FAIL pe_rsp: got n=%0d err=%b tree=%0d data=%h cyc=%0d, required n=1 err=1 tree=1 data=0 cyc=%0d",
                  rq.size(), rq[0].err, rq[0].tree, rq[0].data, rq[0].cyc, a + 4);
      end
   endtask

   task automatic test_tree_full();
      int a;
      int n_push = 0;
      int n_pop = 0;
      int bad = 0;
      do_reset();
      for (int i = 0; i < 340; i++) send(1'b0, 2'd0, 16'(i + 1));
      send(1'b0, 2'd0, 16'h00AA);
      a = last_acc;
      idle(8);
      foreach (sq[i]) if (!sq[i].pop) n_push++;
      checks++;
      if (n_push !== 340) begin
         failures++;
         $display("FAIL tf_push_count: got %0d, required 340", n_push);
      end
      checks++;
      if (rq.size() !== 1 || rq[0].err !== 1'b1 || rq[0].tree !== 2'd0 || rq[0].data !== 16'h00AA || rq[0].cyc !== a + 4) begin
         failures++;
         $display("FAIL tf_reject: got n=%0d err=%b tree=%0d data=%h cyc=%0d, required n=1 err=1 tree=0 data=00aa cyc=%0d",
                  rq.size(), rq[0].err, rq[0].tree, rq[0].data, rq[0].cyc, a + 4);
      end
      sq.delete();
      rq.delete();
      for (int i = 0; i < 340; i++) send(1'b1, 2'd0, 16'h0);
      send(1'b1, 2'd0, 16'h0);
      send(1'b0, 2'd0, 16'h00BB);
      idle(8);
      n_push = 0;
      foreach (sq[i]) if (sq[i].pop) n_pop++; else n_push++;
      checks++;
      if (n_pop !== 340 || n_push !== 1 || sq[sq.size()-1].data !== 16'h00BB) begin
         failures++;
         $display("FAIL tf_drain_strobes: got pops=%0d pushes=%0d last_data=%h, required 340/1/00bb",
                  n_pop, n_push, sq[sq.size()-1].data);
      end
      for (int i = 0; i < 340 && i < rq.size(); i++) if (rq[i].err !== 1'b0 || rq[i].data !== 16'hC0DE) bad++;
      checks++;
      if (rq.size() !== 341 || bad !== 0) begin
         failures++;
         $display("FAIL tf_drain_rsps: got n=%0d bad=%0d, required n=341 bad=0", rq.size(), bad);
      end
      checks++;
      if (rq[rq.size()-1].err !== 1'b1 || rq[rq.size()-1].data !== 16'h0) begin
         failures++;
         $display("FAIL tf_underflow: got err=%b data=%h, required err=1 data=0",
                  rq[rq.size()-1].err, rq[rq.size()-1].data);
      end
   endtask

   task automatic test_backpressure();
      int acc = 0;
      int r;
      do_reset();
      i_task_fifo_full = 1'b1;
      for (int k = 0; k < 10; k++) begin
         i_req_valid = 1'b1;
         i_req_op = 1'b0;
         i_req_tree_id = 2'd1;
         i_req_data = 16'(k + 1);
         if (o_req_ready) acc++;
         @(negedge i_clk);
      end
      i_req_valid = 1'b0;
      idle(2);
      checks++;
      if (acc !== 8 || o_req_ready !== 1'b0 || o_q_count !== 4'd8) begin
         failures++;
         $display("FAIL bp_fill: got acc=%0d ready=%b count=%0d, required 8/0/8", acc, o_req_ready, o_q_count);
      end
      checks++;
      if (sq.size() !== 0) begin
         failures++;
         $display("FAIL bp_no_strobe: got %0d strobes, required 0", sq.size());
      end
      i_task_fifo_full = 1'b0;
      r = cyc;
      idle(12);
      checks++;
      if (sq.size() !== 8) begin
         failures++;
         $display("FAIL bp_drain_count: got %0d, required 8", sq.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (sq[i].pop !== 1'b0 || sq[i].tree !== 2'd1 || sq[i].data !== 16'(i + 1) || sq[i].cyc !== r + 1 + i) begin
               failures++;
               $display("FAIL bp_drain%0d: got data=%h tree=%0d cyc=%0d, required data=%h tree=1 cyc=%0d",
                        i, sq[i].data, sq[i].tree, sq[i].cyc, 16'(i + 1), r + 1 + i);
            end
         end
      end
   endtask

   task automatic test_interleave();
      int a;
      do_reset();
      script.push_back(16'h0077);
      send(1'b0, 2'd0, 16'h0033);
      send(1'b1, 2'd3, 16'h0);
      a = last_acc;
      send(1'b1, 2'd0, 16'h0);
      idle(8);
      checks++;
      if (rq.size() !== 2) begin
         failures++;
         $display("FAIL il_rsp_count: got %0d, required 2", rq.size());
      end else begin
         checks++;
         if (rq[0].err !== 1'b1 || rq[0].tree !== 2'd3 || rq[0].data !== 16'h0 || rq[0].cyc !== a + 4) begin
            failures++;
            $display("FAIL il_rsp0: got err=%b tree=%0d data=%h cyc=%0d, required err=1 tree=3 data=0 cyc=%0d",
                     rq[0].err, rq[0].tree, rq[0].data, rq[0].cyc, a + 4);
         end
         checks++;
         if (rq[1].err !== 1'b0 || rq[1].tree !== 2'd0 || rq[1].data !== 16'h0077 || rq[1].cyc !== a + 5) begin
            failures++;
            $display("FAIL il_rsp1: got err=%b tree=%0d data=%h cyc=%0d, required err=0 tree=0 data=0077 cyc=%0d",
                     rq[1].err, rq[1].tree, rq[1].data, rq[1].cyc, a + 5);
         end
      end
   endtask

   task automatic test_reset_inflight();
      do_reset();
      send(1'b0, 2'd2, 16'h0001);
      idle(4);
      rq.delete();
      send(1'b1, 2'd2, 16'h0);
      send(1'b1, 2'd1, 16'h0);
      idle(1);
      i_arst_n = 1'b0;
      idle(2);
      i_arst_n = 1'b1;
      idle(10);
      checks++;
      if (rq.size() !== 0) begin
         failures++;
         $display("FAIL ri_no_rsp: got %0d responses, required 0", rq.size());
      end
      checks++;
      if (o_q_count !== 4'd0 || o_req_ready !== 1'b1) begin
         failures++;
         $display("FAIL ri_queue: got count=%0d ready=%b, required 0/1", o_q_count, o_req_ready);
      end
      send(1'b1, 2'd2, 16'h0);
      idle(8);
      checks++;
      if (rq.size() !== 1 || rq[0].err !== 1'b1) begin
         failures++;
         $display("FAIL ri_count_cleared: got n=%0d err=%b, required n=1 err=1", rq.size(), rq[0].err);
      end
   endtask

   initial begin
      @(negedge i_clk);
      test_reset();
      test_push_pop();
      test_pop_empty();
      test_tree_full();
      test_backpressure();
      test_interleave();
      test_reset_inflight();
      checks++;
      if (viol !== 0) begin
         failures++;
         $display("FAIL strobe_encoding: got %0d illegal strobe cycles, required 0", viol);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
